// File: rtl/regfile_wb.sv
// Writeback stage: picks the result from ALU, memory or link address, commits it
// to the 32-entry register file and serves two decode read ports with write-through.
module regfile_wb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
  input  logic [DATA_W-1:0]                   result,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   rtd,
  output logic [DATA_W-1:0]                   data
);
  // In-flight write wins over the stored value so decode sees it this cycle.
  always_comb begin
    data = '0;
    if (addr == '0)                data = '0;
    else if (we && (rtd == addr))  data = result;
    else                           data = regs[addr];
  end
endmodule

module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [DATA_W-1:0] DMOutW,
  input  logic [DATA_W-1:0] PCPlus4W,
  input  logic [ADDR_W-1:0] rtdW,
  input  logic              RFWEW,
  input  logic              MtoRFSelW,
  input  logic              JumpW,
  input  logic [ADDR_W-1:0] RFRA1,
  input  logic [ADDR_W-1:0] RFRA2,
  output logic [DATA_W-1:0] RFRD1,
  output logic [DATA_W-1:0] RFRD2,
  output logic [DATA_W-1:0] ResultW,
  output logic [CNT_W-1:0]  WBCount
);
  localparam int NREG   = 2**ADDR_W;
  localparam int NUM_RD = 2;

  logic [NREG-1:0][DATA_W-1:0]   regs;
  logic [CNT_W-1:0]              wb_cnt;
  logic [DATA_W-1:0]             result;
  logic                          commit;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  always_comb begin
    result = ALUOutW;
    if (JumpW)          result = PCPlus4W;
    else if (MtoRFSelW) result = DMOutW;
  end

  // Register 0 is hardwired; its writes neither store nor count.
  assign commit = RFWEW && (rtdW != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs   <= '0;
      wb_cnt <= '0;
    end else if (commit) begin
      regs[rtdW] <= result;
      wb_cnt     <= wb_cnt + CNT_W'(1);
    end
  end

  assign rd_addr = {RFRA2, RFRA1};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_wb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .addr   (rd_addr[g]),
      .regs   (regs),
      .result (result),
      .we     (RFWEW),
      .rtd    (rtdW),
      .data   (rd_data[g])
    );
  end

  assign RFRD1   = rd_data[0];
  assign RFRD2   = rd_data[1];
  assign ResultW = result;
  assign WBCount = wb_cnt;
endmodule
